// File: rtl/cdb_arbiter.sv
// cdb_arbiter: rotating-priority arbiter for the common data bus; grants one
// eligible station per cycle and drives the registered broadcast it snoops from.
module cdb_arbiter #(
    parameter int NSRC = 4,
    parameter int DW   = 32,
    parameter int LW   = 5
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic [NSRC-1:0]    Breq,
    input  logic [NSRC*LW-1:0] ReqLabel,
    input  logic [NSRC*DW-1:0] ReqData,
    input  logic               Stall,
    output logic [NSRC-1:0]    BreqAC,
    output logic               BCEN,
    output logic [LW-1:0]      BClabel,
    output logic [DW-1:0]      BCdata,
    output logic [15:0]        BCcount
);
    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [PW-1:0]   ptr, g, idx;
    logic [NSRC-1:0] elig;
    logic            found, grant;

    // Scan from lowest to highest priority so the last hit is the first in search order.
    always_comb begin
        elig  = '0;
        found = 1'b0;
        g     = ptr;
        idx   = ptr;
        for (int i = 0; i < NSRC; i++)
            elig[i] = Breq[i] && (ReqLabel[i*LW +: LW] != '0);
        for (int k = NSRC - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NSRC);
            if (elig[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign grant  = found && !Stall && nRST;
    assign BreqAC = grant ? ({{(NSRC-1){1'b0}}, 1'b1} << g) : '0;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr     <= '0;
            BCEN    <= 1'b0;
            BClabel <= '0;
            BCdata  <= '0;
            BCcount <= '0;
        end else begin
            BCEN    <= grant;
            BClabel <= grant ? ReqLabel[int'(g)*LW +: LW] : '0;
            BCdata  <= grant ? ReqData[int'(g)*DW +: DW] : '0;
            if (grant) begin
                ptr     <= PW'((int'(g) + 1) % NSRC);
                BCcount <= BCcount + 16'd1;
            end
        end
    end
endmodule
